// File: rtl/rf_wb_arbiter_if.sv
// Register-file writeback bus: pipeline write, MDU issue/result handshake,
// regfile write port and busy scoreboard.
interface rf_wb_arbiter_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
);
    logic                   pipe_we;
    logic [ADDR_W-1:0]      pipe_waddr;
    logic [DATA_W-1:0]      pipe_wdata;
    logic                   pipe_stall;
    logic                   mdu_issue;
    logic [ADDR_W-1:0]      mdu_issue_rd;
    logic                   mdu_valid;
    logic                   mdu_ready;
    logic [ADDR_W-1:0]      mdu_waddr;
    logic [DATA_W-1:0]      mdu_wdata;
    logic                   rf_we;
    logic [ADDR_W-1:0]      rf_waddr;
    logic [DATA_W-1:0]      rf_wdata;
    logic [(1<<ADDR_W)-1:0] busy;

    modport slave (
        input  pipe_we, pipe_waddr, pipe_wdata, mdu_issue, mdu_issue_rd,
        input  mdu_valid, mdu_waddr, mdu_wdata,
        output pipe_stall, mdu_ready, rf_we, rf_waddr, rf_wdata, busy
    );

    modport master (
        output pipe_we, pipe_waddr, pipe_wdata, mdu_issue, mdu_issue_rd,
        output mdu_valid, mdu_waddr, mdu_wdata,
        input  pipe_stall, mdu_ready, rf_we, rf_waddr, rf_wdata, busy
    );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Shares the regfile write port between pipeline writeback and a FIFO-buffered MDU,
// with a starvation guard and a scoreboard of outstanding MDU destinations.
module rf_wb_arbiter #(
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned ADDR_W       = 5,
    parameter int unsigned FIFO_DEPTH   = 2,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input logic            clk,
    input logic            rst,
    rf_wb_arbiter_if.slave bus
);
    localparam int unsigned NRegs   = 1 << ADDR_W;
    localparam int unsigned PtrW    = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW    = PtrW + 1;
    localparam int unsigned StarveW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CntW-1:0]    CntFull   = CntW'(FIFO_DEPTH);
    localparam logic [StarveW-1:0] StarveMax = StarveW'(STARVE_LIMIT);

    logic [ADDR_W-1:0]  fifo_waddr_q [FIFO_DEPTH];
    logic [ADDR_W-1:0]  fifo_waddr_d [FIFO_DEPTH];
    logic [DATA_W-1:0]  fifo_wdata_q [FIFO_DEPTH];
    logic [DATA_W-1:0]  fifo_wdata_d [FIFO_DEPTH];
    logic [PtrW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0]    count_q, count_d;
    logic [StarveW-1:0] starve_q, starve_d;
    logic [NRegs-1:0]   busy_q, busy_d;

    logic              full, head_valid, force_grant, push, pop, grant, mdu_ready;
    logic              pipe_stall;
    logic [ADDR_W-1:0] head_waddr, grant_waddr;
    logic [DATA_W-1:0] head_wdata, grant_wdata;

    always_comb begin
        full        = (count_q == CntFull);
        head_valid  = (count_q != '0);
        head_waddr  = fifo_waddr_q[rd_ptr_q];
        head_wdata  = fifo_wdata_q[rd_ptr_q];
        force_grant = head_valid && (starve_q == StarveMax);
        mdu_ready   = !full && !rst;
        push        = bus.mdu_valid && mdu_ready;
        pop         = 1'b0;
        grant       = 1'b0;
        pipe_stall  = 1'b0;
        grant_waddr = '0;
        grant_wdata = '0;
        if (!rst) begin
            if (force_grant) begin
                pipe_stall  = 1'b1;
                pop         = 1'b1;
                grant       = 1'b1;
                grant_waddr = head_waddr;
                grant_wdata = head_wdata;
            end else if (bus.pipe_we) begin
                grant       = 1'b1;
                grant_waddr = bus.pipe_waddr;
                grant_wdata = bus.pipe_wdata;
            end else if (head_valid) begin
                pop         = 1'b1;
                grant       = 1'b1;
                grant_waddr = head_waddr;
                grant_wdata = head_wdata;
            end
        end
    end

    always_comb begin
        fifo_waddr_d = fifo_waddr_q;
        fifo_wdata_d = fifo_wdata_q;
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        if (push) begin
            fifo_waddr_d[wr_ptr_q] = bus.mdu_waddr;
            fifo_wdata_d[wr_ptr_q] = bus.mdu_wdata;
            wr_ptr_d               = wr_ptr_q + PtrW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        count_d = count_q + {{PtrW{1'b0}}, push} - {{PtrW{1'b0}}, pop};

        // Only a head that lost arbitration ages; any pop or empty FIFO restarts the count.
        if (pop || !head_valid) begin
            starve_d = '0;
        end else if (starve_q != StarveMax) begin
            starve_d = starve_q + StarveW'(1);
        end else begin
            starve_d = starve_q;
        end

        // Set is applied after clear so a same-cycle reissue of the popped rd stays busy.
        busy_d = busy_q;
        if (pop) begin
            busy_d[head_waddr] = 1'b0;
        end
        if (bus.mdu_issue && (bus.mdu_issue_rd != '0)) begin
            busy_d[bus.mdu_issue_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            starve_q <= '0;
            busy_q   <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            starve_q <= starve_d;
            busy_q   <= busy_d;
        end
    end

    // Payload storage needs no reset; validity is carried by count_q.
    always_ff @(posedge clk) begin
        fifo_waddr_q <= fifo_waddr_d;
        fifo_wdata_q <= fifo_wdata_d;
    end

    assign bus.pipe_stall = pipe_stall;
    assign bus.mdu_ready  = mdu_ready;
    assign bus.rf_we      = grant && (grant_waddr != '0);
    assign bus.rf_waddr   = grant_waddr;
    assign bus.rf_wdata   = grant_wdata;
    assign bus.busy       = busy_q;
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: reset, MDU latency, starvation guard, FIFO full,
// r0 writes, scoreboard set-wins and mid-operation reset.
module tb_rf_wb_arbiter;
    localparam int unsigned DW = 32;
    localparam int unsigned AW = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   pass_cnt = 0;
    int   total_cnt = 0;

    rf_wb_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    rf_wb_arbiter #(
        .DATA_W(DW), .ADDR_W(AW), .FIFO_DEPTH(2), .STARVE_LIMIT(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.pipe_we      = 1'b0;
        bus.pipe_waddr   = '0;
        bus.pipe_wdata   = '0;
        bus.mdu_issue    = 1'b0;
        bus.mdu_issue_rd = '0;
        bus.mdu_valid    = 1'b0;
        bus.mdu_waddr    = '0;
        bus.mdu_wdata    = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.pipe_we = 1'b1; bus.pipe_waddr = 5'd3; bus.pipe_wdata = 32'hAAAA;
        bus.mdu_valid = 1'b1; bus.mdu_waddr = 5'd4; bus.mdu_wdata = 32'hBBBB;
        for (int i = 0; i < 2; i++) begin
            #1;
            total_cnt++;
            if (bus.rf_we !== 1'b0) $display("FAIL reset_rf_we got %0b want 0", bus.rf_we);
            else pass_cnt++;
            total_cnt++;
            if (bus.mdu_ready !== 1'b0) $display("FAIL reset_mdu_ready got %0b want 0", bus.mdu_ready);
            else pass_cnt++;
            total_cnt++;
            if (bus.pipe_stall !== 1'b0) $display("FAIL reset_stall got %0b want 0", bus.pipe_stall);
            else pass_cnt++;
            tick();
        end
        total_cnt++;
        if (bus.busy !== '0) $display("FAIL reset_busy got %h want 0", bus.busy);
        else pass_cnt++;
        rst = 1'b0;
        idle_inputs();
        #1;
        total_cnt++;
        if (bus.mdu_ready !== 1'b1) $display("FAIL release_mdu_ready got %0b want 1", bus.mdu_ready);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_single_mdu();
        bus.mdu_issue = 1'b1; bus.mdu_issue_rd = 5'd5;
        tick();
        bus.mdu_issue = 1'b0;
        #1;
        total_cnt++;
        if (bus.busy[5] !== 1'b1) $display("FAIL issue_busy5 got %0b want 1", bus.busy[5]);
        else pass_cnt++;
        tick();
        tick();
        bus.mdu_valid = 1'b1; bus.mdu_waddr = 5'd5; bus.mdu_wdata = 32'h1234;
        #1;
        total_cnt++;
        if (bus.rf_we !== 1'b0) $display("FAIL no_bypass_we got %0b want 0", bus.rf_we);
        else pass_cnt++;
        tick();
        bus.mdu_valid = 1'b0;
        #1;
        total_cnt++;
        if ({bus.rf_we, bus.rf_waddr, bus.rf_wdata} !== {1'b1, 5'd5, 32'h1234})
            $display("FAIL mdu_write got we=%0b a=%0d d=%h want we=1 a=5 d=1234",
                     bus.rf_we, bus.rf_waddr, bus.rf_wdata);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (bus.busy[5] !== 1'b0) $display("FAIL pop_busy5 got %0b want 0", bus.busy[5]);
        else pass_cnt++;
        total_cnt++;
        if (bus.rf_we !== 1'b0) $display("FAIL after_pop_we got %0b want 0", bus.rf_we);
        else pass_cnt++;
    endtask

    task automatic test_starve();
        bus.pipe_we = 1'b1; bus.pipe_waddr = 5'd8; bus.pipe_wdata = 32'h88;
        bus.mdu_valid = 1'b1; bus.mdu_waddr = 5'd9; bus.mdu_wdata = 32'h99;
        tick();
        bus.mdu_valid = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            #1;
            total_cnt++;
            if ({bus.pipe_stall, bus.rf_we, bus.rf_waddr} !== {1'b0, 1'b1, 5'd8})
                $display("FAIL starve_pipe_c%0d got stall=%0b we=%0b a=%0d want 0 1 8",
                         c, bus.pipe_stall, bus.rf_we, bus.rf_waddr);
            else pass_cnt++;
            tick();
        end
        #1;
        total_cnt++;
        if ({bus.pipe_stall, bus.rf_we, bus.rf_waddr, bus.rf_wdata} !== {2'b11, 5'd9, 32'h99})
            $display("FAIL starve_force got stall=%0b we=%0b a=%0d d=%h want 1 1 9 99",
                     bus.pipe_stall, bus.rf_we, bus.rf_waddr, bus.rf_wdata);
        else pass_cnt++;
        tick();
        total_cnt++;
        if ({bus.pipe_stall, bus.rf_we, bus.rf_waddr, bus.rf_wdata} !== {2'b01, 5'd8, 32'h88})
            $display("FAIL starve_replay got stall=%0b we=%0b a=%0d d=%h want 0 1 8 88",
                     bus.pipe_stall, bus.rf_we, bus.rf_waddr, bus.rf_wdata);
        else pass_cnt++;
        tick();
        idle_inputs();
        tick();
    endtask

    task automatic test_full();
        logic [AW-1:0] exp_a [3];
        logic [DW-1:0] exp_d [3];
        logic [AW-1:0] got_a [3];
        logic [DW-1:0] got_d [3];
        int            force_c [3];
        int            exp_fc [3];
        int            accept_c [3];
        int            idx = 0;
        int            nforced = 0;
        int            pipe_bad = 0;
        logic          accept;
        exp_a = '{5'd10, 5'd11, 5'd12};
        exp_d = '{32'hA0, 32'hA1, 32'hA2};
        exp_fc = '{5, 10, 15};
        for (int i = 0; i < 3; i++) begin
            got_a[i] = '0; got_d[i] = '0; force_c[i] = -1; accept_c[i] = -1;
        end
        bus.pipe_we = 1'b1; bus.pipe_waddr = 5'd8; bus.pipe_wdata = 32'h88;
        for (int c = 0; c < 25; c++) begin
            bus.mdu_valid = 1'b0;
            if (idx < 3) begin
                bus.mdu_valid = 1'b1;
                bus.mdu_waddr = exp_a[idx];
                bus.mdu_wdata = exp_d[idx];
            end
            #1;
            if (bus.pipe_stall === 1'b1) begin
                if (nforced < 3) begin
                    got_a[nforced]   = bus.rf_waddr;
                    got_d[nforced]   = bus.rf_wdata;
                    force_c[nforced] = c;
                end
                nforced++;
            end else if (!(bus.rf_we === 1'b1 && bus.rf_waddr === 5'd8)) begin
                pipe_bad++;
            end
            accept = bus.mdu_valid && bus.mdu_ready;
            if (accept && idx < 3) accept_c[idx] = c;
            tick();
            if (accept) idx++;
        end
        idle_inputs();
        total_cnt++;
        if (accept_c[1] !== 1) $display("FAIL full_second_accept got c%0d want c1", accept_c[1]);
        else pass_cnt++;
        total_cnt++;
        if (accept_c[2] !== 6) $display("FAIL full_third_accept got c%0d want c6", accept_c[2]);
        else pass_cnt++;
        total_cnt++;
        if (nforced !== 3) $display("FAIL full_forced_count got %0d want 3", nforced);
        else pass_cnt++;
        total_cnt++;
        if (pipe_bad !== 0) $display("FAIL full_pipe_grants got %0d bad want 0", pipe_bad);
        else pass_cnt++;
        for (int i = 0; i < 3; i++) begin
            total_cnt++;
            if (got_a[i] !== exp_a[i] || got_d[i] !== exp_d[i] || force_c[i] !== exp_fc[i])
                $display("FAIL full_order%0d got a=%0d d=%h c%0d want a=%0d d=%h c%0d", i,
                         got_a[i], got_d[i], force_c[i], exp_a[i], exp_d[i], exp_fc[i]);
            else pass_cnt++;
        end
        tick();
    endtask

    task automatic test_r0();
        bus.mdu_valid = 1'b1; bus.mdu_waddr = 5'd0; bus.mdu_wdata = 32'hFFFF;
        tick();
        bus.mdu_valid = 1'b0;
        #1;
        total_cnt++;
        if (bus.rf_we !== 1'b0) $display("FAIL r0_we got %0b want 0", bus.rf_we);
        else pass_cnt++;
        tick();
        total_cnt++;
        if ({bus.rf_we, bus.rf_waddr, bus.rf_wdata} !== {1'b0, 5'd0, 32'h0})
            $display("FAIL r0_popped got we=%0b a=%0d d=%h want idle", bus.rf_we, bus.rf_waddr,
                     bus.rf_wdata);
        else pass_cnt++;
        total_cnt++;
        if (bus.busy[0] !== 1'b0) $display("FAIL r0_busy0 got %0b want 0", bus.busy[0]);
        else pass_cnt++;
    endtask

    task automatic test_set_wins_and_reset();
        bus.mdu_issue = 1'b1; bus.mdu_issue_rd = 5'd7;
        tick();
        bus.mdu_issue = 1'b0;
        bus.mdu_valid = 1'b1; bus.mdu_waddr = 5'd7; bus.mdu_wdata = 32'h77;
        tick();
        bus.mdu_valid = 1'b0;
        bus.mdu_issue = 1'b1; bus.mdu_issue_rd = 5'd7;
        #1;
        total_cnt++;
        if ({bus.rf_we, bus.rf_waddr} !== {1'b1, 5'd7})
            $display("FAIL setwin_pop got we=%0b a=%0d want 1 7", bus.rf_we, bus.rf_waddr);
        else pass_cnt++;
        tick();
        bus.mdu_issue = 1'b0;
        #1;
        total_cnt++;
        if (bus.busy[7] !== 1'b1) $display("FAIL setwin_busy7 got %0b want 1", bus.busy[7]);
        else pass_cnt++;
        // Fill the FIFO behind a continuous pipeline write, then reset.
        bus.pipe_we = 1'b1; bus.pipe_waddr = 5'd8; bus.pipe_wdata = 32'h88;
        bus.mdu_issue = 1'b1; bus.mdu_issue_rd = 5'd13;
        bus.mdu_valid = 1'b1; bus.mdu_waddr = 5'd13; bus.mdu_wdata = 32'hD13;
        tick();
        bus.mdu_issue = 1'b0;
        bus.mdu_waddr = 5'd14; bus.mdu_wdata = 32'hD14;
        tick();
        bus.mdu_valid = 1'b0;
        #1;
        total_cnt++;
        if ({bus.mdu_ready, bus.busy[13]} !== 2'b01)
            $display("FAIL full_state got ready=%0b busy13=%0b want 0 1", bus.mdu_ready,
                     bus.busy[13]);
        else pass_cnt++;
        rst = 1'b1;
        #1;
        total_cnt++;
        if ({bus.rf_we, bus.pipe_stall, bus.mdu_ready, bus.rf_waddr, bus.rf_wdata} !== '0)
            $display("FAIL midrst_outputs got we=%0b st=%0b rdy=%0b a=%0d d=%h want all 0",
                     bus.rf_we, bus.pipe_stall, bus.mdu_ready, bus.rf_waddr, bus.rf_wdata);
        else pass_cnt++;
        tick();
        rst = 1'b0;
        idle_inputs();
        #1;
        total_cnt++;
        if (bus.busy !== '0) $display("FAIL midrst_busy got %h want 0", bus.busy);
        else pass_cnt++;
        total_cnt++;
        if ({bus.mdu_ready, bus.rf_we, bus.rf_wdata} !== {1'b1, 1'b0, 32'h0})
            $display("FAIL midrst_empty got rdy=%0b we=%0b d=%h want 1 0 0", bus.mdu_ready,
                     bus.rf_we, bus.rf_wdata);
        else pass_cnt++;
        tick();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_single_mdu();
        test_starve();
        test_full();
        test_r0();
        test_set_wins_and_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
